clock_mode_controller: RTL
==========================

Name: clock_mode_controller

Overview:
- Top-level mode sequencer for the digital clock/alarm.
- Drives the enable and direction inputs of two time-counter instances: the running clock counter and an alarm-setting counter (minutes/hours only).
- Decodes debounced button pulses into clock-adjust and alarm-adjust modes, detects the alarm match, and controls alarm ringing, LED and display select.

Parameters:
- RING_SECONDS, 60, maximum ring duration in 1 Hz ticks before auto-silence (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tick_1hz  in  1  one-cycle pulse once per second, synchronous to clk
- btn_c  in  1  one-cycle debounced pulse; mode advance
- btn_u  in  1  one-cycle debounced pulse; increment
- btn_d  in  1  one-cycle debounced pulse; decrement
- btn_l  in  1  one-cycle debounced pulse; select hours field
- btn_r  in  1  one-cycle debounced pulse; select minutes field
- alarm_on  in  1  alarm arm switch, already synchronised
- clk_hours  in  5  running clock hours, binary 0..23
- clk_minutes  in  6  running clock minutes, binary 0..59
- clk_seconds  in  6  running clock seconds, binary 0..59
- alm_hours  in  5  alarm hours, binary 0..23
- alm_minutes  in  6  alarm minutes, binary 0..59
- enable_seconds  out  1  to clock counter
- adjust_enable_minutes  out  1  to clock counter
- adjust_enable_hours  out  1  to clock counter
- alm_adjust_minutes  out  1  to alarm counter minutes enable
- alm_adjust_hours  out  1  to alarm counter hours enable
- Up_down  out  1  shared direction: 1 = count up, 0 = count down
- show_alarm  out  1  display mux select: 1 = alarm time
- blink  out  1  blink phase for the field being adjusted
- mode_leds  out  4  one-hot: {ALM_MIN, ALM_HR, CLK_MIN, CLK_HR}
- alarm_led  out  1  high while ringing
- buzzer  out  1  high while ringing, gated by blink phase

Behaviour:
- FSM states: CLOCK, ADJ_CLK_HR, ADJ_CLK_MIN, ADJ_ALM_HR, ADJ_ALM_MIN, RING.
- Reset (rst low, async):
  - State = CLOCK; all outputs 0, except Up_down = 1.
  - Ring counter = 0; blink = 0.
- CLOCK:
  - enable_seconds = tick_1hz (combinational pass-through, same cycle).
  - All adjust outputs 0; Up_down = 1; show_alarm = 0; mode_leds = 0.
- btn_c transitions:
  - CLOCK -> ADJ_CLK_HR -> ADJ_CLK_MIN -> ADJ_ALM_HR -> ADJ_ALM_MIN -> CLOCK.
  - btn_l in any ADJ state: jump to the HR state of the same group (clock or alarm).
  - btn_r in any ADJ state: jump to the MIN state of the same group.
  - Priority within a cycle: btn_c > btn_l > btn_r.
- ADJ_CLK_HR / ADJ_CLK_MIN:
  - enable_seconds = 0 (clock paused); ticks are dropped.
  - btn_u or btn_d: registered pulse exactly one cycle on adjust_enable_hours or adjust_enable_minutes, per state.
  - Up_down is registered in the same edge as the enable (1 for btn_u, 0 for btn_d) and holds its value afterwards.
  - Latency from button to enable is 1 clk.
- ADJ_ALM_HR / ADJ_ALM_MIN:
  - Clock keeps running (enable_seconds = tick_1hz).
  - btn_u/btn_d drive alm_adjust_hours/alm_adjust_minutes with the same 1-cycle registered rule.
  - show_alarm = 1.
  - Up_down is forced 1 on any cycle where enable_seconds = 1, so a tick coincident with an alarm adjust pulse takes priority. The adjust pulse is then delayed one cycle; it is never lost.
- Simultaneous btn_u and btn_d: ignored, no pulse.
- btn_u/btn_d in the same cycle as btn_c/l/r: mode change wins, count press ignored.
- blink:
  - In ADJ states, toggles on each tick_1hz; cleared to 0 on every state change.
  - In CLOCK, blink = 0.
  - In RING, toggles on each tick.
- Alarm match:
  - Condition: state == CLOCK, alarm_on = 1, tick_1hz = 1, clk_hours == alm_hours, clk_minutes == alm_minutes, clk_seconds == 59.
  - Effect: next state RING, entered as the minute rolls over. Match is evaluated on the pre-increment values.
- RING:
  - Clock runs (enable_seconds = tick_1hz); alarm_led = 1; buzzer = blink.
  - Ring counter increments per tick.
  - Return to CLOCK on any button pulse, on alarm_on = 0, or when the counter reaches RING_SECONDS.
  - The button press that silences does not also change mode.
  - Ring counter is cleared on exit.
- Match never fires in ADJ states. Leaving ADJ does not retro-trigger a match.
- Out-of-range inputs (e.g. hours > 23) are compared as-is; no saturation.
- All state and output registers clear asynchronously when rst goes low, including mid-adjust and mid-ring. A partial enable pulse is truncated.

Test Plan:
- Reset/run: assert rst low mid-ring; release, then 3 ticks -> state CLOCK, alarm_led 0, enable_seconds pulses coincide with each tick, adjust outputs 0.
- Clock adjust: btn_c, then btn_u twice and btn_d once in ADJ_CLK_HR -> three 1-cycle adjust_enable_hours pulses, each 1 clk after its press, Up_down 1,1,0 on those cycles; enable_seconds 0 despite 5 ticks.
- Field select: btn_c, btn_r, btn_u -> mode_leds 0010, one adjust_enable_minutes pulse; btn_l -> mode_leds 0001.
- Alarm adjust with tick collision: in ADJ_ALM_MIN, btn_d in the same cycle as tick -> enable_seconds with Up_down 1 first, alm_adjust_minutes with Up_down 0 one cycle later; show_alarm 1.
- Alarm fire: alarm 07:30, clock 07:30:59, alarm_on 1, tick -> RING next cycle, alarm_led 1; btn_u -> CLOCK, no adjust pulse.
- Timeout/disarm: RING_SECONDS = 4 -> after 4 ticks returns to CLOCK. Repeat with alarm_on dropped after 1 tick -> CLOCK immediately. Same match with alarm_on 0 -> no RING.

Source files
------------

// File: rtl/clock_mode_controller_if.sv
// Signal bundle between the mode controller and its surroundings: button pulses,
// time values from both counters, and the counter/display/alarm controls.
interface clock_mode_controller_if;
    logic       tick_1hz;
    logic       btn_c;
    logic       btn_u;
    logic       btn_d;
    logic       btn_l;
    logic       btn_r;
    logic       alarm_on;
    logic [4:0] clk_hours;
    logic [5:0] clk_minutes;
    logic [5:0] clk_seconds;
    logic [4:0] alm_hours;
    logic [5:0] alm_minutes;

    logic       enable_seconds;
    logic       adjust_enable_minutes;
    logic       adjust_enable_hours;
    logic       alm_adjust_minutes;
    logic       alm_adjust_hours;
    logic       Up_down;
    logic       show_alarm;
    logic       blink;
    logic [3:0] mode_leds;
    logic       alarm_led;
    logic       buzzer;

    modport master (
        output tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_on,
        output clk_hours, clk_minutes, clk_seconds, alm_hours, alm_minutes,
        input  enable_seconds, adjust_enable_minutes, adjust_enable_hours,
        input  alm_adjust_minutes, alm_adjust_hours, Up_down, show_alarm,
        input  blink, mode_leds, alarm_led, buzzer
    );

    modport slave (
        input  tick_1hz, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_on,
        input  clk_hours, clk_minutes, clk_seconds, alm_hours, alm_minutes,
        output enable_seconds, adjust_enable_minutes, adjust_enable_hours,
        output alm_adjust_minutes, alm_adjust_hours, Up_down, show_alarm,
        output blink, mode_leds, alarm_led, buzzer
    );
endinterface

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital clock/alarm: steers the clock and alarm-setting
// counters, detects the alarm match and drives ringing, LEDs and display select.
module clock_mode_controller #(
    parameter int RING_SECONDS = 60
) (
    input logic                    clk,
    input logic                    rst,
    clock_mode_controller_if.slave bus
);
    typedef enum logic [2:0] {
        CLOCK       = 3'd0,
        ADJ_CLK_HR  = 3'd1,
        ADJ_CLK_MIN = 3'd2,
        ADJ_ALM_HR  = 3'd3,
        ADJ_ALM_MIN = 3'd4,
        RING        = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] ring_cnt_reg, ring_cnt_next;
    logic       blink_reg, blink_next;
    logic       up_down_reg, up_down_next;
    logic       adj_hr_reg, adj_hr_next;
    logic       adj_min_reg, adj_min_next;
    logic       alm_hr_pend_reg, alm_hr_pend_next;
    logic       alm_min_pend_reg, alm_min_pend_next;

    logic       mode_btn;
    logic       any_btn;
    logic       count_press;
    logic       alarm_match;
    logic       enable_seconds_w;
    logic       in_adj;
    logic [8:0] ring_inc;
    logic [3:0] mode_leds_w;

    assign mode_btn    = bus.btn_c | bus.btn_l | bus.btn_r;
    assign any_btn     = mode_btn | bus.btn_u | bus.btn_d;
    assign count_press = (bus.btn_u ^ bus.btn_d) & ~mode_btn;
    assign ring_inc    = {1'b0, ring_cnt_reg} + 9'd1;
    assign in_adj      = (state_reg == ADJ_CLK_HR) || (state_reg == ADJ_CLK_MIN) ||
                         (state_reg == ADJ_ALM_HR) || (state_reg == ADJ_ALM_MIN);

    // Matching on second 59 with the tick means RING starts as the minute rolls over.
    assign alarm_match = (state_reg == CLOCK) && bus.alarm_on && bus.tick_1hz &&
                         (bus.clk_hours == bus.alm_hours) &&
                         (bus.clk_minutes == bus.alm_minutes) &&
                         (bus.clk_seconds == 6'd59);

    assign enable_seconds_w = bus.tick_1hz && rst &&
                              (state_reg != ADJ_CLK_HR) && (state_reg != ADJ_CLK_MIN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLOCK: begin
                if (alarm_match)    state_next = RING;
                else if (bus.btn_c) state_next = ADJ_CLK_HR;
            end
            ADJ_CLK_HR, ADJ_CLK_MIN: begin
                if (bus.btn_c)
                    state_next = (state_reg == ADJ_CLK_HR) ? ADJ_CLK_MIN : ADJ_ALM_HR;
                else if (bus.btn_l) state_next = ADJ_CLK_HR;
                else if (bus.btn_r) state_next = ADJ_CLK_MIN;
            end
            ADJ_ALM_HR, ADJ_ALM_MIN: begin
                if (bus.btn_c)
                    state_next = (state_reg == ADJ_ALM_HR) ? ADJ_ALM_MIN : CLOCK;
                else if (bus.btn_l) state_next = ADJ_ALM_HR;
                else if (bus.btn_r) state_next = ADJ_ALM_MIN;
            end
            RING: begin
                if (any_btn || !bus.alarm_on ||
                    (bus.tick_1hz && (ring_inc >= 9'(RING_SECONDS))))
                    state_next = CLOCK;
            end
            default: state_next = CLOCK;
        endcase

        blink_next = blink_reg;
        if ((state_next != state_reg) || (state_reg == CLOCK))
            blink_next = 1'b0;
        else if (bus.tick_1hz)
            blink_next = ~blink_reg;

        ring_cnt_next = '0;
        if ((state_reg == RING) && (state_next == RING))
            ring_cnt_next = ring_cnt_reg + {7'd0, bus.tick_1hz};

        adj_hr_next  = count_press && (state_reg == ADJ_CLK_HR);
        adj_min_next = count_press && (state_reg == ADJ_CLK_MIN);

        up_down_next = up_down_reg;
        if (count_press && in_adj)
            up_down_next = bus.btn_u;

        // Alarm requests wait out any cycle where the running clock needs Up_down=1.
        alm_hr_pend_next  = (alm_hr_pend_reg && enable_seconds_w) ||
                            (count_press && (state_reg == ADJ_ALM_HR));
        alm_min_pend_next = (alm_min_pend_reg && enable_seconds_w) ||
                            (count_press && (state_reg == ADJ_ALM_MIN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= CLOCK;
            ring_cnt_reg     <= '0;
            blink_reg        <= 1'b0;
            up_down_reg      <= 1'b1;
            adj_hr_reg       <= 1'b0;
            adj_min_reg      <= 1'b0;
            alm_hr_pend_reg  <= 1'b0;
            alm_min_pend_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ring_cnt_reg     <= ring_cnt_next;
            blink_reg        <= blink_next;
            up_down_reg      <= up_down_next;
            adj_hr_reg       <= adj_hr_next;
            adj_min_reg      <= adj_min_next;
            alm_hr_pend_reg  <= alm_hr_pend_next;
            alm_min_pend_reg <= alm_min_pend_next;
        end
    end

    // LED bit gi lights for the adjust state encoded as gi+1.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mode_led
        assign mode_leds_w[gi] = (state_reg == state_t'(3'(gi + 1)));
    end

    assign bus.enable_seconds        = enable_seconds_w;
    assign bus.adjust_enable_hours   = adj_hr_reg;
    assign bus.adjust_enable_minutes = adj_min_reg;
    assign bus.alm_adjust_hours      = alm_hr_pend_reg && !enable_seconds_w;
    assign bus.alm_adjust_minutes    = alm_min_pend_reg && !enable_seconds_w;
    assign bus.Up_down               = ((state_reg == CLOCK) || (state_reg == RING) ||
                                        enable_seconds_w) ? 1'b1 : up_down_reg;
    assign bus.show_alarm            = (state_reg == ADJ_ALM_HR) || (state_reg == ADJ_ALM_MIN);
    assign bus.blink                 = blink_reg;
    assign bus.mode_leds             = mode_leds_w;
    assign bus.alarm_led             = (state_reg == RING);
    assign bus.buzzer                = (state_reg == RING) && blink_reg;
endmodule
